tm_master_multislave_tagged: RTL and testbench

- Credit/flow regulator between a NoC master bundle and the NoC, for a master that sends to several slaves (dest+VC).
- Generalised successor of the single-slave-at-a-time scheme:
  - tracks up to MAX_ACTIVE slaves with outstanding requests at once, each in its own slot;
  - returns credits per slave, using a tagged reply source.
- Stalls only on global credit exhaustion, per-slave credit exhaustion, or when a new slave arrives and all slots are busy.

---
 rtl/tm_master_multislave_tagged.sv | 169 ++++++++++++++++
 tb/tb_tm_master_multislave_tagged.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm_master_multislave_tagged.sv
// Multi-slave credit regulator: per-slave tagged slots plus a global credit pool.
// Optional statistics counters are enabled by defining TM_STATS_EN.
module tm_master_multislave_tagged #(
    parameter int unsigned NUM_CREDITS      = 32,
    parameter int unsigned SLAVE_CREDITS    = 8,
    parameter int unsigned MAX_ACTIVE       = 4,
    parameter int unsigned ADDRESS_WIDTH    = 4,
    parameter int unsigned VC_ADDRESS_WIDTH = 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      send_valid,
    input  logic [ADDRESS_WIDTH-1:0]                  send_dest,
    input  logic [VC_ADDRESS_WIDTH-1:0]               send_vc,
    input  logic                                      send_ready_in,
    output logic                                      send_ready_out,
    input  logic                                      receive_valid,
    input  logic [ADDRESS_WIDTH+VC_ADDRESS_WIDTH-1:0] receive_src,
    output logic [$clog2(NUM_CREDITS+1)-1:0]          num_outstanding,
    output logic [$clog2(MAX_ACTIVE+1)-1:0]           active_slots,
`ifdef TM_STATS_EN
    output logic [31:0]                               stall_cycles,
    output logic [31:0]                               switch_count,
`endif
    output logic                                      err
);

    localparam int unsigned TagW     = ADDRESS_WIDTH + VC_ADDRESS_WIDTH;
    localparam int unsigned CntW     = $clog2(NUM_CREDITS + 1);
    localparam int unsigned SlotCntW = $clog2(SLAVE_CREDITS + 1);
    localparam int unsigned ActW     = $clog2(MAX_ACTIVE + 1);
    localparam int unsigned IdxW     = (MAX_ACTIVE > 1) ? $clog2(MAX_ACTIVE) : 1;

    logic [MAX_ACTIVE-1:0] active_q, active_d;
    logic [TagW-1:0]       tag_q [MAX_ACTIVE];
    logic [TagW-1:0]       tag_d [MAX_ACTIVE];
    logic [SlotCntW-1:0]   cnt_q [MAX_ACTIVE];
    logic [SlotCntW-1:0]   cnt_d [MAX_ACTIVE];
    logic [CntW-1:0]       outst_q, outst_d;
    logic                  err_q, err_d;

    logic [TagW-1:0] send_tag;
    logic            hit, free_any, rx_hit, hit_room;
    logic [IdxW-1:0] hit_idx, free_idx, rx_idx;
    logic            xfer, rx_ok;
    logic [ActW-1:0] act_cnt;

    assign send_tag = {send_dest, send_vc};

    // Lookups run on registered state only, so a slot freed this cycle is not reusable yet.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        rx_hit   = 1'b0;
        rx_idx   = '0;
        act_cnt  = '0;
        for (int i = int'(MAX_ACTIVE) - 1; i >= 0; i--) begin
            if (active_q[i] && tag_q[i] == send_tag) begin
                hit     = 1'b1;
                hit_idx = IdxW'(i);
            end
            if (!active_q[i]) begin
                free_any = 1'b1;
                free_idx = IdxW'(i);
            end
            if (active_q[i] && tag_q[i] == receive_src) begin
                rx_hit = 1'b1;
                rx_idx = IdxW'(i);
            end
            act_cnt = act_cnt + ActW'(active_q[i]);
        end
    end

    assign hit_room       = cnt_q[hit_idx] < SlotCntW'(SLAVE_CREDITS);
    assign send_ready_out = rst & send_ready_in & (outst_q < CntW'(NUM_CREDITS)) &
                            (hit ? hit_room : free_any);
    assign xfer           = send_valid & send_ready_out;
    assign rx_ok          = receive_valid & rx_hit & (outst_q != '0);
    assign err_d          = err_q | (receive_valid & ~rx_ok);

    always_comb begin
        active_d = active_q;
        tag_d    = tag_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < int'(MAX_ACTIVE); i++) begin
            if (xfer && !hit && free_idx == IdxW'(i)) begin
                active_d[i] = 1'b1;
                tag_d[i]    = send_tag;
                cnt_d[i]    = SlotCntW'(1);
            end else if (xfer && hit && hit_idx == IdxW'(i)) begin
                // Same-slot send and reply cancel out; the slot stays ACTIVE.
                if (!(rx_ok && rx_idx == IdxW'(i))) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (rx_ok && rx_idx == IdxW'(i)) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
                if (cnt_q[i] == SlotCntW'(1)) begin
                    active_d[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        outst_d = outst_q;
        unique case ({xfer, rx_ok})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q <= '0;
            outst_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < int'(MAX_ACTIVE); i++) begin
                tag_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            active_q <= active_d;
            outst_q  <= outst_d;
            err_q    <= err_d;
            for (int i = 0; i < int'(MAX_ACTIVE); i++) begin
                tag_q[i] <= tag_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign num_outstanding = outst_q;
    assign active_slots    = act_cnt;
    assign err             = err_q;

`ifdef TM_STATS_EN
    logic [31:0]     stall_q, switch_q;
    logic [TagW-1:0] last_tag_q;
    logic            seen_q;

    // The very first transfer after reset has no predecessor and is not a switch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q    <= '0;
            switch_q   <= '0;
            last_tag_q <= '0;
            seen_q     <= 1'b0;
        end else begin
            if (send_valid && !send_ready_out && !(&stall_q)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (xfer) begin
                last_tag_q <= send_tag;
                seen_q     <= 1'b1;
                if (seen_q && last_tag_q != send_tag && !(&switch_q)) begin
                    switch_q <= switch_q + 1'b1;
                end
            end
        end
    end

    assign stall_cycles = stall_q;
    assign switch_count = switch_q;
`endif

endmodule

// File: tb/tb_tm_master_multislave_tagged.sv
// Self-checking bench: directed scenarios plus random traffic against a per-tag credit model.
module tb_tm_master_multislave_tagged;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       send_valid = 1'b0;
    logic [3:0] send_dest = '0;
    logic [1:0] send_vc = '0;
    logic       send_ready_in = 1'b0;
    logic       send_ready_out;
    logic       receive_valid = 1'b0;
    logic [5:0] receive_src = '0;
    logic [5:0] num_outstanding;
    logic [2:0] active_slots;
    logic       err;
`ifdef TM_STATS_EN
    logic [31:0] stall_cycles, switch_count;
`endif

    tm_master_multislave_tagged dut (
        .clk             (clk),
        .rst             (rst),
        .send_valid      (send_valid),
        .send_dest       (send_dest),
        .send_vc         (send_vc),
        .send_ready_in   (send_ready_in),
        .send_ready_out  (send_ready_out),
        .receive_valid   (receive_valid),
        .receive_src     (receive_src),
        .num_outstanding (num_outstanding),
        .active_slots    (active_slots),
`ifdef TM_STATS_EN
        .stall_cycles    (stall_cycles),
        .switch_count    (switch_count),
`endif
        .err             (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding count per tag; a tag with count>0 occupies one slot.
    int mcnt [64];
    int mtot;
    bit merr;

    function automatic int m_nactive();
        int n = 0;
        for (int t = 0; t < 64; t++) if (mcnt[t] > 0) n++;
        return n;
    endfunction

    function automatic bit m_ready(input int tag, input bit ri);
        if (!ri || mtot >= 32) return 1'b0;
        if (mcnt[tag] > 0) return mcnt[tag] < 8;
        return m_nactive() < 4;
    endfunction

    function automatic void m_clear();
        for (int t = 0; t < 64; t++) mcnt[t] = 0;
        mtot = 0;
        merr = 1'b0;
    endfunction

    // One clock: drive at posedge+1, sample ready at +3, update model, return at next posedge+1.
    task automatic cycle(input bit v, input int tag, input bit ri, input bit rv, input int src,
                         output bit rdy_seen, output bit rdy_exp);
        bit xf, rok;
        send_valid    = v;
        {send_dest, send_vc} = 6'(tag);
        send_ready_in = ri;
        receive_valid = rv;
        receive_src   = 6'(src);
        #2;
        rdy_seen = send_ready_out;
        rdy_exp  = m_ready(tag, ri);
        xf  = v && rdy_exp;
        rok = rv && mcnt[src] > 0;
        if (xf) begin mcnt[tag]++; mtot++; end
        if (rok) begin mcnt[src]--; mtot--; end
        if (rv && !rok) merr = 1'b1;
        @(posedge clk);
        #1;
        send_valid    = 1'b0;
        receive_valid = 1'b0;
    endtask

    task automatic probe(input int tag, output bit rdy);
        send_valid    = 1'b0;
        receive_valid = 1'b0;
        send_ready_in = 1'b1;
        {send_dest, send_vc} = 6'(tag);
        #1;
        rdy = send_ready_out;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        send_valid = 1'b0;
        receive_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_clear();
    endtask

    task automatic test_reset();
        send_valid = 1'b1;
        send_ready_in = 1'b1;
        #1;
        checks++;
        if (send_ready_out !== 1'b0 || num_outstanding !== 6'd0 || active_slots !== 3'd0 ||
            err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b outst=%0d act=%0d err=%b required 0 0 0 0",
                     send_ready_out, num_outstanding, active_slots, err);
        end
        do_reset();
    endtask

    task automatic test_single_slave();
        bit r, e;
        for (int i = 0; i < 5; i++) begin
            cycle(1, 'h12, 1, 0, 0, r, e);
            checks++;
            if (r !== 1'b1) begin
                errors++;
                $display("FAIL single_ready[%0d]: got %b required 1", i, r);
            end
        end
        checks++;
        if (num_outstanding !== 6'd5 || active_slots !== 3'd1) begin
            errors++;
            $display("FAIL single_fill: outst=%0d act=%0d required 5 1", num_outstanding,
                     active_slots);
        end
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 1, 'h12, r, e);
        checks++;
        if (num_outstanding !== 6'd0 || active_slots !== 3'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: outst=%0d act=%0d err=%b required 0 0 0",
                     num_outstanding, active_slots, err);
        end
    endtask

    task automatic test_slave_credits();
        bit r, e;
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 'h12, 1, 0, 0, r, e);
        probe('h12, r);
        checks++;
        if (r !== 1'b0) begin
            errors++;
            $display("FAIL slave_full_12: ready=%b required 0", r);
        end
        probe('h20, r);
        checks++;
        if (r !== 1'b1) begin
            errors++;
            $display("FAIL slave_other_20: ready=%b required 1", r);
        end
        // Reply and blocked request in the same cycle: no look-ahead credit.
        cycle(1, 'h12, 1, 1, 'h12, r, e);
        checks++;
        if (r !== 1'b0) begin
            errors++;
            $display("FAIL slave_no_lookahead: ready=%b required 0", r);
        end
        probe('h12, r);
        checks++;
        if (r !== 1'b1 || num_outstanding !== 6'd7) begin
            errors++;
            $display("FAIL slave_credit_back: ready=%b outst=%0d required 1 7", r,
                     num_outstanding);
        end
    endtask

    task automatic test_slots_full();
        bit r, e;
        do_reset();
        for (int t = 1; t <= 4; t++) cycle(1, t, 1, 0, 0, r, e);
        checks++;
        if (active_slots !== 3'd4) begin
            errors++;
            $display("FAIL slots_count: act=%0d required 4", active_slots);
        end
        cycle(1, 5, 1, 1, 2, r, e);
        checks++;
        if (r !== 1'b0) begin
            errors++;
            $display("FAIL slots_new_blocked: ready=%b required 0", r);
        end
        cycle(1, 5, 1, 0, 0, r, e);
        checks++;
        if (r !== 1'b1 || active_slots !== 3'd4 || num_outstanding !== 6'd4) begin
            errors++;
            $display("FAIL slots_reuse: ready=%b act=%0d outst=%0d required 1 4 4", r,
                     active_slots, num_outstanding);
        end
    endtask

    task automatic test_global_credits();
        bit r, e;
        do_reset();
        for (int t = 1; t <= 4; t++)
            for (int i = 0; i < 8; i++) cycle(1, t, 1, 0, 0, r, e);
        checks++;
        if (num_outstanding !== 6'd32) begin
            errors++;
            $display("FAIL global_fill: outst=%0d required 32", num_outstanding);
        end
        for (int t = 1; t <= 5; t++) begin
            probe(t, r);
            checks++;
            if (r !== 1'b0) begin
                errors++;
                $display("FAIL global_block[%0d]: ready=%b required 0", t, r);
            end
        end
        cycle(0, 0, 1, 1, 3, r, e);
        probe(3, r);
        checks++;
        if (num_outstanding !== 6'd31 || r !== 1'b1) begin
            errors++;
            $display("FAIL global_return: outst=%0d ready=%b required 31 1", num_outstanding, r);
        end
    endtask

    task automatic test_simultaneous();
        bit r, e;
        do_reset();
        cycle(1, 'h12, 1, 0, 0, r, e);
        cycle(1, 'h12, 1, 1, 'h12, r, e);
        checks++;
        if (r !== 1'b1 || num_outstanding !== 6'd1 || active_slots !== 3'd1) begin
            errors++;
            $display("FAIL simul_same_slot: ready=%b outst=%0d act=%0d required 1 1 1", r,
                     num_outstanding, active_slots);
        end
        cycle(0, 0, 1, 1, 'h12, r, e);
        checks++;
        if (num_outstanding !== 6'd0 || active_slots !== 3'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL simul_drain: outst=%0d act=%0d err=%b required 0 0 0",
                     num_outstanding, active_slots, err);
        end
    endtask

    task automatic test_errors();
        bit r, e;
        do_reset();
        cycle(0, 0, 1, 1, 'h12, r, e);
        checks++;
        if (err !== 1'b1 || num_outstanding !== 6'd0) begin
            errors++;
            $display("FAIL err_empty: err=%b outst=%0d required 1 0", err, num_outstanding);
        end
        do_reset();
        cycle(1, 'h12, 1, 0, 0, r, e);
        cycle(1, 'h12, 1, 0, 0, r, e);
        cycle(0, 0, 1, 1, 'h3F, r, e);
        checks++;
        if (err !== 1'b1 || num_outstanding !== 6'd2 || active_slots !== 3'd1) begin
            errors++;
            $display("FAIL err_unknown: err=%b outst=%0d act=%0d required 1 2 1", err,
                     num_outstanding, active_slots);
        end
    endtask

    task automatic test_async_reset();
        bit r, e;
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 'h07, 1, 0, 0, r, e);
        send_valid    = 1'b1;
        send_ready_in = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (num_outstanding !== 6'd0 || active_slots !== 3'd0 || err !== 1'b0 ||
            send_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: outst=%0d act=%0d err=%b ready=%b required 0 0 0 0",
                     num_outstanding, active_slots, err, send_ready_out);
        end
        send_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_clear();
        cycle(0, 0, 1, 1, 'h07, r, e);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL stale_reply: err=%b required 1", err);
        end
    endtask

    task automatic test_random();
        bit r, e;
        int pool [6] = '{'h12, 'h20, 'h05, 'h31, 'h0A, 'h2C};
        int na, tag, src;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            tag = pool[$urandom_range(5)];
            src = ($urandom_range(99) < 97) ? pool[$urandom_range(5)] : 'h3F;
            cycle($urandom_range(99) < 70, tag, $urandom_range(9) != 0,
                  $urandom_range(99) < 40, src, r, e);
            checks++;
            if (r !== e) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b required %b", c, r, e);
            end
            na = m_nactive();
            checks++;
            if (num_outstanding !== mtot[5:0] || active_slots !== na[2:0] || err !== merr) begin
                errors++;
                $display("FAIL rand_state[%0d]: outst=%0d act=%0d err=%b required %0d %0d %b",
                         c, num_outstanding, active_slots, err, mtot, na, merr);
            end
        end
    endtask

    initial begin
        m_clear();
        test_reset();
        test_single_slave();
        test_slave_credits();
        test_slots_full();
        test_global_credits();
        test_simultaneous();
        test_errors();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
